// File: rtl/pln_datapath_if.sv
// pln_datapath_if
//   Bundles the instruction/write-back inputs and all decoded/datapath
//   outputs of pln_datapath.
//   master : drives instr and the write-back port, observes the results.
//   slave  : the datapath itself.
//   Signals: instr[15:0], wb_en, wb_addr[2:0], wb_data[15:0] (to datapath);
//            alu_ctrl[3:0], reg_dst/reg_rs1/reg_rs2[2:0], imm_se[15:0],
//            reg_write, alu_src_imm, mem_write, reg_write_back_sel,
//            comparator_ctrl[2:0], instr_class[1:0], reg_a/reg_b[15:0],
//            alu_result[15:0] (from datapath).
interface pln_datapath_if;
   logic [15:0] instr;
   logic        wb_en;
   logic [2:0]  wb_addr;
   logic [15:0] wb_data;
   logic [3:0]  alu_ctrl;
   logic [2:0]  reg_dst;
   logic [2:0]  reg_rs1;
   logic [2:0]  reg_rs2;
   logic [15:0] imm_se;
   logic        reg_write;
   logic        alu_src_imm;
   logic        mem_write;
   logic        reg_write_back_sel;
   logic [2:0]  comparator_ctrl;
   logic [1:0]  instr_class;
   logic [15:0] reg_a;
   logic [15:0] reg_b;
   logic [15:0] alu_result;

   modport master (
      output instr, wb_en, wb_addr, wb_data,
      input  alu_ctrl, reg_dst, reg_rs1, reg_rs2, imm_se, reg_write,
             alu_src_imm, mem_write, reg_write_back_sel, comparator_ctrl,
             instr_class, reg_a, reg_b, alu_result
   );

   modport slave (
      input  instr, wb_en, wb_addr, wb_data,
      output alu_ctrl, reg_dst, reg_rs1, reg_rs2, imm_se, reg_write,
             alu_src_imm, mem_write, reg_write_back_sel, comparator_ctrl,
             instr_class, reg_a, reg_b, alu_result
   );
endinterface

// File: rtl/pln_datapath.sv
// pln_datapath
//   Single-cycle decode / register-read / ALU slice of a small 16-bit core.
//   The instruction decoder, both register read ports, the B-operand mux and
//   the ALU are combinational; the only state is an 8x16 register file whose
//   entry 0 is hardwired to zero.
//   Ports:
//     clk : clock, register-file writes on the rising edge
//     rst : asynchronous active-high reset, clears the register file
//     bus : pln_datapath_if.slave (instruction, write-back port, decoded
//           control fields, register read data, ALU result)
module pln_datapath (
   input  logic                 clk,
   input  logic                 rst,
   pln_datapath_if.slave        bus
);

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_AND  = 4'd2;
   localparam logic [3:0] ALU_OR   = 4'd3;
   localparam logic [3:0] ALU_XOR  = 4'd4;
   localparam logic [3:0] ALU_SLL  = 4'd5;
   localparam logic [3:0] ALU_SRL  = 4'd6;
   localparam logic [3:0] ALU_SRA  = 4'd7;
   localparam logic [3:0] ALU_SLT  = 4'd8;
   localparam logic [3:0] ALU_SLTU = 4'd9;
   localparam logic [3:0] ALU_PASS = 4'd10;

   logic [15:0] regs [8];
   logic [15:0] operand_b;

   // ALU: add/sub wrap modulo 2^16, shifts use only B[3:0], codes 11..15 give 0.
   function automatic logic [15:0] alu_op(input logic [3:0]  op,
                                          input logic [15:0] a,
                                          input logic [15:0] b);
      logic signed [15:0] a_s;
      logic signed [15:0] b_s;
      logic        [15:0] r;
      a_s = a;
      b_s = b;
      case (op)
         ALU_ADD:  r = a + b;
         ALU_SUB:  r = a - b;
         ALU_AND:  r = a & b;
         ALU_OR:   r = a | b;
         ALU_XOR:  r = a ^ b;
         ALU_SLL:  r = a << b[3:0];
         ALU_SRL:  r = a >> b[3:0];
         ALU_SRA:  r = a_s >>> b[3:0];
         ALU_SLT:  r = {15'd0, (a_s < b_s)};
         ALU_SLTU: r = {15'd0, (a < b)};
         ALU_PASS: r = b;
         default:  r = 16'd0;
      endcase
      return r;
   endfunction

   // Instruction decoder
   always_comb begin
      bus.alu_ctrl           = ALU_ADD;
      bus.reg_dst            = 3'd0;
      bus.reg_rs1            = 3'd0;
      bus.reg_rs2            = 3'd0;
      bus.imm_se             = 16'd0;
      bus.reg_write          = 1'b0;
      bus.alu_src_imm        = 1'b0;
      bus.mem_write          = 1'b0;
      bus.reg_write_back_sel = 1'b0;
      bus.comparator_ctrl    = 3'd0;
      bus.instr_class        = bus.instr[15:14];
      case (bus.instr[15:14])
         2'b00: begin
            bus.alu_ctrl  = bus.instr[13:10];
            bus.reg_dst   = bus.instr[9:7];
            bus.reg_rs1   = bus.instr[6:4];
            bus.reg_rs2   = bus.instr[3:1];
            bus.reg_write = 1'b1;
         end
         2'b01: begin
            bus.reg_rs1     = bus.instr[8:6];
            bus.imm_se      = {{10{bus.instr[5]}}, bus.instr[5:0]};
            bus.alu_src_imm = 1'b1;
            case (bus.instr[13:12])
               2'b00: begin
                  bus.reg_dst   = bus.instr[11:9];
                  bus.reg_write = 1'b1;
               end
               2'b01: begin
                  bus.reg_dst            = bus.instr[11:9];
                  bus.reg_write          = 1'b1;
                  bus.reg_write_back_sel = 1'b1;
               end
               2'b10: begin
                  // STORE reuses the destination field as the data source.
                  bus.reg_rs2   = bus.instr[11:9];
                  bus.mem_write = 1'b1;
               end
               default: ;
            endcase
         end
         2'b10: begin
            bus.comparator_ctrl = bus.instr[13:11];
            bus.reg_rs1         = bus.instr[8:6];
            bus.reg_rs2         = bus.instr[5:3];
            bus.alu_ctrl        = ALU_SUB;
         end
         default: begin
            bus.comparator_ctrl = 3'b111;
            bus.imm_se          = {{4{bus.instr[11]}}, bus.instr[11:0]};
            bus.alu_src_imm     = 1'b1;
         end
      endcase
   end

   // Register read ports (r0 forced to zero), B-mux and ALU
   always_comb begin
      bus.reg_a      = (bus.reg_rs1 == 3'd0) ? 16'd0 : regs[bus.reg_rs1];
      bus.reg_b      = (bus.reg_rs2 == 3'd0) ? 16'd0 : regs[bus.reg_rs2];
      operand_b      = bus.alu_src_imm ? bus.imm_se : bus.reg_b;
      bus.alu_result = alu_op(bus.alu_ctrl, bus.reg_a, operand_b);
   end

   // Register file: reset wins over a coincident write; no write-to-read bypass.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 8; i++) regs[i] <= 16'd0;
      end else if (bus.wb_en && (bus.wb_addr != 3'd0)) begin
         regs[bus.wb_addr] <= bus.wb_data;
      end
   end

endmodule

// File: tb/tb_pln_datapath.sv
module tb_pln_datapath;

   typedef struct packed {
      logic [3:0]  alu;
      logic [2:0]  dst;
      logic [2:0]  rs1;
      logic [2:0]  rs2;
      logic [15:0] imm;
      logic [3:0]  flags;   // {reg_write, alu_src_imm, mem_write, reg_write_back_sel}
      logic [2:0]  cmp;
      logic [1:0]  cls;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] res;
   } exp_t;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;
   logic [15:0] mregs [8];
   exp_t sb_q [$];

   pln_datapath_if bus ();

   pln_datapath dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] model_alu(input logic [3:0] op, input logic [15:0] a,
                                             input logic [15:0] b);
      logic [15:0] r;
      int          sh;
      sh = int'(b[3:0]);
      case (op)
         4'd0:  r = a + b;
         4'd1:  r = a + ~b + 16'd1;
         4'd2:  r = a & b;
         4'd3:  r = a | b;
         4'd4:  r = a ^ b;
         4'd5:  r = a << sh;
         4'd6:  r = a >> sh;
         4'd7: begin
            r = a;
            for (int k = 0; k < sh; k++) r = {r[15], r[15:1]};
         end
         4'd8:  r = (a[15] != b[15]) ? {15'd0, a[15]} : {15'd0, (a < b)};
         4'd9:  r = {15'd0, (a < b)};
         4'd10: r = b;
         default: r = 16'd0;
      endcase
      return r;
   endfunction

   function automatic exp_t model(input logic [15:0] i);
      exp_t e;
      e     = '0;
      e.cls = i[15:14];
      if (i[15:14] == 2'b00) begin
         e.alu = i[13:10]; e.dst = i[9:7]; e.rs1 = i[6:4]; e.rs2 = i[3:1];
         e.flags = 4'b1000;
      end else if (i[15:14] == 2'b01) begin
         e.rs1 = i[8:6];
         e.imm = {{10{i[5]}}, i[5:0]};
         e.flags[2] = 1'b1;
         if (i[13:12] == 2'b00) begin
            e.dst = i[11:9]; e.flags[3] = 1'b1;
         end else if (i[13:12] == 2'b01) begin
            e.dst = i[11:9]; e.flags[3] = 1'b1; e.flags[0] = 1'b1;
         end else if (i[13:12] == 2'b10) begin
            e.rs2 = i[11:9]; e.flags[1] = 1'b1;
         end
      end else if (i[15:14] == 2'b10) begin
         e.cmp = i[13:11]; e.rs1 = i[8:6]; e.rs2 = i[5:3]; e.alu = 4'd1;
      end else begin
         e.cmp = 3'b111;
         e.imm = {{4{i[11]}}, i[11:0]};
         e.flags[2] = 1'b1;
      end
      e.a   = mregs[e.rs1];
      e.b   = mregs[e.rs2];
      e.res = model_alu(e.alu, e.a, e.flags[2] ? e.imm : e.b);
      return e;
   endfunction

   task automatic compare_front();
      exp_t e;
      e = sb_q.pop_front();
      chk("alu_ctrl",   {12'd0, bus.alu_ctrl},        {12'd0, e.alu});
      chk("reg_dst",    {13'd0, bus.reg_dst},         {13'd0, e.dst});
      chk("reg_rs1",    {13'd0, bus.reg_rs1},         {13'd0, e.rs1});
      chk("reg_rs2",    {13'd0, bus.reg_rs2},         {13'd0, e.rs2});
      chk("imm_se",     bus.imm_se,                   e.imm);
      chk("flags",      {12'd0, bus.reg_write, bus.alu_src_imm, bus.mem_write,
                         bus.reg_write_back_sel},     {12'd0, e.flags});
      chk("cmp_ctrl",   {13'd0, bus.comparator_ctrl}, {13'd0, e.cmp});
      chk("instr_cls",  {14'd0, bus.instr_class},     {14'd0, e.cls});
      chk("reg_a",      bus.reg_a,                    e.a);
      chk("reg_b",      bus.reg_b,                    e.b);
      chk("alu_result", bus.alu_result,               e.res);
   endtask

   task automatic drive_instr(input logic [15:0] i);
      @(negedge clk);
      bus.instr = i;
      sb_q.push_back(model(i));
      #1;
      compare_front();
   endtask

   task automatic wr(input logic [2:0] a, input logic [15:0] d);
      @(negedge clk);
      bus.wb_en   = 1'b1;
      bus.wb_addr = a;
      bus.wb_data = d;
      @(negedge clk);
      bus.wb_en = 1'b0;
      if (a != 3'd0) mregs[a] = d;
   endtask

   function automatic logic [15:0] rtype(input logic [3:0] op, input logic [2:0] d,
                                         input logic [2:0] s1, input logic [2:0] s2);
      return {2'b00, op, d, s1, s2, 1'b0};
   endfunction

   initial begin
      n_checks = 0;
      n_fail   = 0;
      for (int k = 0; k < 8; k++) mregs[k] = 16'd0;
      rst         = 1'b1;
      bus.instr   = rtype(4'd0, 3'd1, 3'd7, 3'd3);
      bus.wb_en   = 1'b0;
      bus.wb_addr = 3'd0;
      bus.wb_data = 16'd0;
      #2;
      chk("rst_reg_a", bus.reg_a, 16'h0000);
      chk("rst_reg_b", bus.reg_b, 16'h0000);
      @(negedge clk);
      rst = 1'b0;

      // Known vectors
      drive_instr(16'h4205);
      chk("v_addi_dst", {13'd0, bus.reg_dst}, 16'd1);
      chk("v_addi_res", bus.alu_result, 16'h0005);
      wr(3'd1, 16'h0005);
      drive_instr(16'h0112);
      chk("v_add_res", bus.alu_result, 16'h000A);
      drive_instr(16'h423F);
      chk("v_imm_neg", bus.imm_se, 16'hFFFF);
      chk("v_imm_res", bus.alu_result, 16'hFFFF);
      drive_instr(16'h6682);
      chk("v_store_mw", {15'd0, bus.mem_write}, 16'd1);
      chk("v_store_rs2", {13'd0, bus.reg_rs2}, 16'd3);

      // ALU sweep
      wr(3'd1, 16'h0003); wr(3'd2, 16'h0005);
      drive_instr(rtype(4'd1, 3'd3, 3'd1, 3'd2));
      chk("v_sub", bus.alu_result, 16'hFFFE);
      wr(3'd1, 16'h8000); wr(3'd2, 16'h0004);
      drive_instr(rtype(4'd7, 3'd3, 3'd1, 3'd2));
      chk("v_sra", bus.alu_result, 16'hF800);
      wr(3'd1, 16'hFFFF); wr(3'd2, 16'h0001);
      drive_instr(rtype(4'd8, 3'd3, 3'd1, 3'd2));
      chk("v_slt", bus.alu_result, 16'h0001);
      drive_instr(rtype(4'd9, 3'd3, 3'd1, 3'd2));
      chk("v_sltu", bus.alu_result, 16'h0000);
      for (int op = 0; op < 16; op++) drive_instr(rtype(op[3:0], 3'd4, 3'd1, 3'd2));

      // r0 ignores writes
      wr(3'd0, 16'h1234);
      drive_instr(rtype(4'd10, 3'd1, 3'd0, 3'd0));
      chk("r0_zero", bus.reg_a, 16'h0000);

      // No bypass: old value before the edge, new value after it
      drive_instr(rtype(4'd0, 3'd1, 3'd5, 3'd5));
      @(negedge clk);
      bus.wb_en = 1'b1; bus.wb_addr = 3'd5; bus.wb_data = 16'hA5A5;
      #1;
      chk("nobyp_old", bus.reg_a, 16'h0000);
      @(posedge clk);
      #1;
      chk("nobyp_new", bus.reg_a, 16'hA5A5);
      bus.wb_en = 1'b0;
      mregs[5] = 16'hA5A5;

      // Random instructions interleaved with writes
      for (int n = 0; n < 60; n++) begin
         if ($urandom_range(0, 2) == 0)
            wr(3'($urandom_range(0, 7)), 16'($urandom));
         drive_instr(16'($urandom));
      end

      // Asynchronous reset mid-cycle
      wr(3'd7, 16'hBEEF);
      drive_instr(rtype(4'd0, 3'd1, 3'd7, 3'd7));
      chk("r7_set", bus.reg_a, 16'hBEEF);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst_a", bus.reg_a, 16'h0000);
      chk("async_rst_res", bus.alu_result, 16'h0000);
      for (int k = 0; k < 8; k++) mregs[k] = 16'd0;

      // Write held during reset is discarded, then lands after release
      bus.instr   = rtype(4'd0, 3'd1, 3'd3, 3'd0);
      bus.wb_en   = 1'b1;
      bus.wb_addr = 3'd3;
      bus.wb_data = 16'h5555;
      @(posedge clk);
      #1;
      chk("rst_wr_drop", bus.reg_a, 16'h0000);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_rel_pre", bus.reg_a, 16'h0000);
      @(posedge clk);
      #1;
      chk("rst_rel_wr", bus.reg_a, 16'h5555);
      bus.wb_en = 1'b0;
      mregs[3] = 16'h5555;
      drive_instr(rtype(4'd2, 3'd1, 3'd3, 3'd3));

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
